// File: rtl/wb_write_queue.sv
// Writeback request queue in front of the register-file write port.
// Retires one entry per granted cycle and forwards pending values to both read ports.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          wbValid,
   input  logic [AW-1:0] wbAddr,
   input  logic [DW-1:0] wbData,
   output logic          wbReady,
   input  logic          drainEn,
   output logic          regWrite,
   output logic [AW-1:0] writeRegAddr,
   output logic [DW-1:0] writeData,
   input  logic [AW-1:0] readReg1Addr,
   input  logic [AW-1:0] readReg2Addr,
   output logic          fwd1Hit,
   output logic [DW-1:0] fwd1Data,
   output logic          fwd2Hit,
   output logic [DW-1:0] fwd2Data,
   output logic          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [AW-1:0] r_mem_addr [DEPTH];
   logic [DW-1:0] r_mem_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;
   logic          r_reg_write;
   logic [AW-1:0] r_write_addr;
   logic [DW-1:0] r_write_data;

   logic          w_ready;
   logic          w_accept;
   logic          w_store;
   logic          w_pop;
   logic [PW:0]   w_count_nxt;
   logic [DW:0]   w_fwd1;
   logic [DW:0]   w_fwd2;

   // Youngest-wins lookup: output register first, then queue entries head..tail-1 override.
   function automatic logic [DW:0] f_lookup(input logic [AW-1:0] addr);
      logic [DW:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      if (addr != '0) begin
         if (r_reg_write && (r_write_addr == addr)) begin
            res = {1'b1, r_write_data};
         end else begin
            res = '0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if (((PW+1)'(i) < r_count) && (r_mem_addr[idx] == addr)) begin
               res = {1'b1, r_mem_data[idx]};
            end else begin
               res = res;
            end
         end
      end else begin
         res = '0;
      end
      return res;
   endfunction

   assign w_ready  = (r_count < FULL_COUNT);
   assign w_accept = wbValid && w_ready;
   assign w_store  = w_accept && (wbAddr != '0);
   assign w_pop    = drainEn && (r_count != '0);

   // Occupancy update for simultaneous store/pop.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_store, w_pop})
         2'b10:   w_count_nxt = r_count + (PW+1)'(1);
         2'b01:   w_count_nxt = r_count - (PW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_addr[i] <= '0;
            r_mem_data[i] <= '0;
         end
      end else begin
         if (w_store) begin
            r_mem_addr[r_tail] <= wbAddr;
            r_mem_data[r_tail] <= wbData;
            r_tail             <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // Register-file write port: one-cycle strobe per retired entry; address/data hold otherwise.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_reg_write  <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
      end else begin
         r_reg_write <= w_pop;
         if (w_pop) begin
            r_write_addr <= r_mem_addr[r_head];
            r_write_data <= r_mem_data[r_head];
         end
      end
   end

   // Forwarding lookups for both read ports.
   always_comb begin
      w_fwd1 = '0;
      w_fwd2 = '0;
      w_fwd1 = f_lookup(readReg1Addr);
      w_fwd2 = f_lookup(readReg2Addr);
   end

   assign wbReady      = w_ready;
   assign regWrite     = r_reg_write;
   assign writeRegAddr = r_write_addr;
   assign writeData    = r_write_data;
   assign fwd1Hit      = w_fwd1[DW];
   assign fwd1Data     = w_fwd1[DW-1:0];
   assign fwd2Hit      = w_fwd2[DW];
   assign fwd2Data     = w_fwd2[DW-1:0];
   assign empty        = (r_count == '0) && !r_reg_write;

endmodule
